// File: rtl/day_of_month.sv
// Day-of-month counter: counts 1..days_in_month, with set-mode press increments and a run-mode carry to the month stage.
// Latency: one clock from tick or press to the new count; an up press lands SYNC_STAGES+1 clocks after the button edge.
// Backpressure: none; the block accepts a tick or press every cycle, and input that is not used is dropped.
module day_of_month #(
    parameter int YEAR_BITS     = 7,
    parameter int SYNC_STAGES   = 2,
    parameter bit UP_ACTIVE_LOW = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 day_tick,
    input  logic                 set,
    input  logic                 up,
    input  logic [3:0]           month,
    input  logic [YEAR_BITS-1:0] year,
    output logic [4:0]           day_count,
    output logic                 day_carry,
    output logic [7:0]           day_bcd
);

    localparam logic UP_RELEASED = UP_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [SYNC_STAGES-1:0] up_sync_q;
    logic                   up_hist_q;
    logic                   press;
    logic                   leap;
    logic [4:0]             days_in_month;
    logic [4:0]             day_next;
    logic [1:0]             bcd_tens;
    logic [3:0]             bcd_units;
    logic                   unused_year_hi;

    // Only the low two year bits matter: every fourth year is leap across 2000..2099.
    assign leap           = (year[1:0] == 2'b00);
    assign unused_year_hi = ^year[YEAR_BITS-1:2];

    always_comb begin
        days_in_month = 5'd31;
        case (month)
            4'd2:                      days_in_month = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   days_in_month = 5'd30;
            default:                   days_in_month = 5'd31;
        endcase
    end

    // The synchroniser and history flop reset to the released level so no press appears after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            up_sync_q <= {SYNC_STAGES{UP_RELEASED}};
            up_hist_q <= UP_RELEASED;
        end else begin
            up_sync_q <= {up_sync_q[SYNC_STAGES-2:0], up};
            up_hist_q <= up_sync_q[SYNC_STAGES-1];
        end
    end

    assign press    = (up_sync_q[SYNC_STAGES-1] != UP_RELEASED) && (up_hist_q == UP_RELEASED);
    assign day_next = (day_count == days_in_month) ? 5'd1 : day_count + 5'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            day_count <= 5'd1;
            day_carry <= 1'b0;
        end else if (day_count > days_in_month) begin
            // The month or year changed under the day; clamping takes priority over any tick or press.
            day_count <= days_in_month;
            day_carry <= 1'b0;
        end else if (set) begin
            day_carry <= 1'b0;
            if (press) begin
                day_count <= day_next;
            end
        end else if (day_tick) begin
            day_count <= day_next;
            day_carry <= (day_count == days_in_month);
        end else begin
            day_carry <= 1'b0;
        end
    end

    always_comb begin
        bcd_tens  = 2'd0;
        bcd_units = day_count[3:0];
        if (day_count >= 5'd30) begin
            bcd_tens  = 2'd3;
            bcd_units = 4'(day_count - 5'd30);
        end else if (day_count >= 5'd20) begin
            bcd_tens  = 2'd2;
            bcd_units = 4'(day_count - 5'd20);
        end else if (day_count >= 5'd10) begin
            bcd_tens  = 2'd1;
            bcd_units = 4'(day_count - 5'd10);
        end
    end

    assign day_bcd = {2'b00, bcd_tens, bcd_units};

endmodule

// File: tb/tb_day_of_month.sv
// Bench for day_of_month: directed calendar scenarios followed by random stimulus,
// every cycle compared against a calendar-level model of the day counter.
module tb_day_of_month;

    localparam int YEAR_BITS   = 7;
    localparam int SYNC_STAGES = 2;

    logic                 clock;
    logic                 reset;
    logic                 day_tick;
    logic                 set;
    logic                 up;
    logic [3:0]           month;
    logic [YEAR_BITS-1:0] year;
    logic [4:0]           day_count;
    logic                 day_carry;
    logic [7:0]           day_bcd;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: calendar day, carry flag, and the button level seen at each past clock edge.
    int m_day   = 1;
    int m_carry = 0;
    int pressed_hist[0:7];

    day_of_month #(
        .YEAR_BITS    (YEAR_BITS),
        .SYNC_STAGES  (SYNC_STAGES),
        .UP_ACTIVE_LOW(1'b1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .day_tick (day_tick),
        .set      (set),
        .up       (up),
        .month    (month),
        .year     (year),
        .day_count(day_count),
        .day_carry(day_carry),
        .day_bcd  (day_bcd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int month_len(int m, int y);
        int lens[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m < 1 || m > 12) return 31;
        if (m == 2 && (y % 4) == 0) return 29;
        return lens[m-1];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("day_count", day_count, m_day);
        check("day_carry", day_carry, m_carry);
        check("day_bcd", day_bcd, ((m_day / 10) << 4) | (m_day % 10));
    endtask

    task automatic model_reset();
        m_day   = 1;
        m_carry = 0;
        for (int i = 0; i < 8; i++) pressed_hist[i] = 0;
    endtask

    // A press is acted on SYNC_STAGES+1 edges after the button goes down.
    task automatic model_edge();
        int  d;
        bit  press;
        d     = month_len(int'(month), int'(year));
        press = (pressed_hist[SYNC_STAGES-1] == 1) && (pressed_hist[SYNC_STAGES] == 0);
        if (m_day > d) begin
            m_day   = d;
            m_carry = 0;
        end else if (set) begin
            m_carry = 0;
            if (press) m_day = (m_day % d) + 1;
        end else if (day_tick) begin
            m_day   = (m_day % d) + 1;
            m_carry = (m_day == 1) ? 1 : 0;
        end else begin
            m_carry = 0;
        end
        for (int i = 7; i > 0; i--) pressed_hist[i] = pressed_hist[i-1];
        pressed_hist[0] = (up == 1'b0) ? 1 : 0;
    endtask

    task automatic cyc();
        @(posedge clock);
        if (reset) model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        day_tick = 1'b1;
        repeat (n) cyc();
        day_tick = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        day_tick = 1'b0;
        set      = 1'b0;
        up       = 1'b1;
        month    = 4'd1;
        year     = 7'd24;
        model_reset();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset_day", day_count, 5'd1);
        check("reset_carry", day_carry, 1'b0);
        check("reset_bcd", day_bcd, 8'h01);
        reset = 1'b1;
        repeat (3) cyc();

        // January: 30 ticks to day 31, 31st wraps with a one-cycle carry
        ticks(30);
        check("jan_day31", day_count, 5'd31);
        check("jan_bcd31", day_bcd, 8'h31);
        ticks(1);
        check("jan_wrap_day", day_count, 5'd1);
        check("jan_wrap_carry", day_carry, 1'b1);
        cyc();
        check("jan_carry_clear", day_carry, 1'b0);

        // February leap / non-leap, then April
        month = 4'd2;
        ticks(28);
        check("feb_leap_day29", day_count, 5'd29);
        ticks(1);
        check("feb_leap_wrap", day_count, 5'd1);
        check("feb_leap_carry", day_carry, 1'b1);
        year = 7'd23;
        ticks(27);
        check("feb_day28", day_count, 5'd28);
        ticks(1);
        check("feb_wrap", day_count, 5'd1);
        check("feb_carry", day_carry, 1'b1);
        month = 4'd4;
        ticks(29);
        check("apr_day30", day_count, 5'd30);
        ticks(1);
        check("apr_wrap", day_count, 5'd1);
        check("apr_carry", day_carry, 1'b1);

        // Set mode in June: one held press wraps 30 -> 1, ticks ignored
        month = 4'd6;
        ticks(29);
        check("jun_day30", day_count, 5'd30);
        set = 1'b1;
        cyc();
        up       = 1'b0;
        day_tick = 1'b1;
        cyc();
        cyc();
        check("press_not_yet", day_count, 5'd30);
        cyc();
        check("press_wrap_day", day_count, 5'd1);
        check("press_no_carry", day_carry, 1'b0);
        repeat (5) cyc();
        check("held_single_inc", day_count, 5'd1);
        up = 1'b1;
        repeat (4) cyc();
        day_tick = 1'b0;
        set      = 1'b0;
        cyc();

        // Clamp: day 31 in January, switch to February 2025 with a tick in the same cycle
        month = 4'd1;
        year  = 7'd25;
        ticks(30);
        check("clamp_pre", day_count, 5'd31);
        month    = 4'd2;
        day_tick = 1'b1;
        cyc();
        check("clamp_day", day_count, 5'd28);
        check("clamp_carry", day_carry, 1'b0);
        day_tick = 1'b0;
        cyc();
        check("clamp_hold", day_count, 5'd28);

        // Asynchronous reset in the middle of a carry cycle
        ticks(1);
        check("pre_reset_carry", day_carry, 1'b1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_carry", day_carry, 1'b0);
        check("async_day", day_count, 5'd1);
        #2;
        reset = 1'b1;
        cyc();

        // Illegal month 0 behaves as 31 days
        month = 4'd0;
        ticks(30);
        check("m0_day31", day_count, 5'd31);
        ticks(1);
        check("m0_wrap", day_count, 5'd1);
        check("m0_carry", day_carry, 1'b1);
        cyc();

        // Random calendar traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) month = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) year  = 7'($urandom_range(0, 99));
            if ($urandom_range(0, 31) == 0) set   = ~set;
            if ($urandom_range(0, 7)  == 0) up    = ~up;
            day_tick = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/day_of_month.md
Name: day_of_month

Overview:
- Day-of-month counter. Sits directly upstream of the month stage and drives that stage's count input with `day_carry`.
- Counts 1..N, where N (28/29/30/31) comes from the current month and year fed back from the month and year stages.
- Supports manual setting through the `set` switch and the `up` pushbutton.
- Fully synchronous to one clock: no clock muxing; `up` is synchronised and edge-detected internally.

Parameters:
- YEAR_BITS, 7, width of the year input; year value is an offset from 2000 (0..99 valid).
- SYNC_STAGES, 2, flip-flop stages in the `up` synchroniser (minimum 2).
- UP_ACTIVE_LOW, 1, 1 = `up` pushbutton reads 0 when pressed (board KEY style).

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- day_tick  input  1  one-cycle enable from the hour stage's carry; advances the day in run mode.
- set  input  1  1 = set mode (SW[0]); 0 = run mode.
- up  input  1  raw pushbutton (KEY[2]); one press = +1 day in set mode.
- month  input  4  current month, 1..12, from the month stage.
- year  input  YEAR_BITS  current year offset from 2000, from the year stage.
- day_count  output  5  current day, 1..31.
- day_carry  output  1  one-cycle pulse when the day wraps from last day to 1 in run mode.
- day_bcd  output  8  BCD of day_count: [7:4] tens, [3:0] units; feeds the 7-segment decoders.

Behaviour:
- Reset (reset=0, asynchronous):
  - day_count=1, day_carry=0, day_bcd=8'h01.
  - Synchroniser and edge-detect flops are cleared to the released-button level, so no spurious press is seen after reset.
- Leap rule: leap = (year[1:0]==0). This is exact for 2000..2099.
- Month length, days_in_month:
  - 2 → 29 if leap, else 28.
  - 4, 6, 9, 11 → 30.
  - 1, 3, 5, 7, 8, 10, 12 → 31.
  - 0 and 13..15 → 31, so illegal months never trap the counter.
- Press detect:
  - `up` passes through SYNC_STAGES flops, then one history flop.
  - press = synchronised level changes from released to pressed.
  - The press pulse is exactly one cycle wide, SYNC_STAGES+1 cycles after the button edge.
  - No debouncing in this block; a clean input gives exactly one increment.
- Next-state priority, evaluated every cycle (first match wins):
  1. Clamp: if day_count > days_in_month, then day_count = days_in_month and day_carry=0. Any coincident tick or press is dropped. This covers month/year changing under the day, e.g. day 31 then month set to 4 → 30.
  2. Set mode (set=1): a press increments day_count. At days_in_month it wraps to 1, and day_carry stays 0. day_tick is ignored.
  3. Run mode (set=0): day_tick increments day_count. At days_in_month it wraps to 1, with day_carry=1 for exactly that cycle. Presses are ignored.
  4. Otherwise hold; day_carry=0.
- day_carry is registered and asserted in the same cycle day_count becomes 1. It is never asserted for two consecutive cycles, and never in set mode.
- After a carry, the month stage updates `month` one or more cycles later. Since day_count is 1 by then, no clamp follows a carry.
- day_bcd is combinational from day_count (tens = day/10, units = day%10); 31 → 8'h31.
- Toggling `set` mid-count has no effect on day_count; mode applies from the next cycle.
- Asserting reset mid-carry clears day_carry immediately.

Test Plan:
- Reset with month=1, year=24 → day_count=1, day_bcd=8'h01, day_carry=0; release reset, no ticks → still 1.
- Run, month=1: 30 day_tick pulses → day_count=31, bcd=8'h31; 31st pulse → day_count=1, day_carry=1 for exactly one cycle.
- Leap check, month=2: year=24 → wrap after day 29; year=23 → wrap after day 28. Carry pulse each time; month=4 → wrap after day 30.
- Set mode, month=6, day=30: one clean up press → day_count=1, day_carry=0. Simultaneous day_tick pulses leave the count unchanged. Increment appears SYNC_STAGES+1 cycles after the press; a held button gives only one increment.
- Clamp: day=31, month changed 1→2 with year=25, and day_tick asserted in the same cycle → next cycle day_count=28, day_carry=0, tick lost.
- Reset asserted asynchronously mid-cycle while day_carry=1 and day=1 → day_carry=0 at once without waiting for clock; month=0 input → counter wraps after 31.
